// File: rtl/button_debounce_events_if.sv
// Button pin and event bundle between the debouncer (slave) and the logic
// that drives the raw pins and consumes the clean levels and strobes (master).
interface button_debounce_events_if #(
  parameter int N_BUTTONS = 4
);
  logic [N_BUTTONS-1:0] buttons_raw;
  logic [N_BUTTONS-1:0] buttons_debounced;
  logic [N_BUTTONS-1:0] pressed;
  logic [N_BUTTONS-1:0] press_pulse;
  logic [N_BUTTONS-1:0] release_pulse;
  logic [N_BUTTONS-1:0] repeat_pulse;

  modport master (
    output buttons_raw,
    input  buttons_debounced, pressed, press_pulse, release_pulse, repeat_pulse
  );

  modport slave (
    input  buttons_raw,
    output buttons_debounced, pressed, press_pulse, release_pulse, repeat_pulse
  );
endinterface

// File: rtl/button_debounce_events.sv
// Per-channel push-button synchroniser, bounce filter and press/release/repeat
// strobe generator; the debounced level keeps the raw pin polarity for the Nios.
module button_debounce_events #(
  parameter int N_BUTTONS       = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CNT_W           = 25
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset,
  button_debounce_events_if.slave  btn
);

  localparam logic                 REL_LVL       = (ACTIVE_LOW != 32'sd0) ? 1'b1 : 1'b0;
  localparam logic [N_BUTTONS-1:0] REL_VEC       = {N_BUTTONS{REL_LVL}};
  localparam logic [CNT_W-1:0]     CNT_ZERO      = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]     CNT_ONE       = CNT_W'(32'sd1);
  localparam logic [CNT_W-1:0]     DB_MAX        = CNT_W'(DEBOUNCE_CYCLES - 32'sd1);
  localparam logic [CNT_W-1:0]     RP_DELAY_MAX  = CNT_W'(REPEAT_DELAY - 32'sd1);
  localparam logic [CNT_W-1:0]     RP_PERIOD_MAX = CNT_W'(REPEAT_PERIOD - 32'sd1);
  localparam logic                 RP_EN         = (REPEAT_DELAY != 32'sd0) ? 1'b1 : 1'b0;

  logic [N_BUTTONS-1:0] s1_r;
  logic [N_BUTTONS-1:0] s2_r;
  logic [N_BUTTONS-1:0] stable_r;
  logic [CNT_W-1:0]     db_cnt_r [N_BUTTONS];
  logic [N_BUTTONS-1:0] debounced_r;
  logic [N_BUTTONS-1:0] pressed_r;
  logic [N_BUTTONS-1:0] press_pulse_r;
  logic [N_BUTTONS-1:0] release_pulse_r;
  logic [N_BUTTONS-1:0] repeat_pulse_r;
  logic [CNT_W-1:0]     rp_cnt_r [N_BUTTONS];
  logic [N_BUTTONS-1:0] rp_first_r;
  logic [N_BUTTONS-1:0] stable_pressed_s;

  assign stable_pressed_s = (ACTIVE_LOW != 32'sd0) ? ~stable_r : stable_r;

  // Synchroniser, bounce filter and the registered level/edge outputs
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      s1_r            <= REL_VEC;
      s2_r            <= REL_VEC;
      stable_r        <= REL_VEC;
      debounced_r     <= REL_VEC;
      pressed_r       <= {N_BUTTONS{1'b0}};
      press_pulse_r   <= {N_BUTTONS{1'b0}};
      release_pulse_r <= {N_BUTTONS{1'b0}};
      for (int i = 0; i < N_BUTTONS; i++) begin
        db_cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      s1_r <= btn.buttons_raw;
      s2_r <= s1_r;
      // A return to the stable value before acceptance restarts the count.
      for (int i = 0; i < N_BUTTONS; i++) begin
        if (s2_r[i] == stable_r[i]) begin
          db_cnt_r[i] <= CNT_ZERO;
        end else if (db_cnt_r[i] == DB_MAX) begin
          stable_r[i] <= s2_r[i];
          db_cnt_r[i] <= CNT_ZERO;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + CNT_ONE;
        end
      end
      debounced_r     <= stable_r;
      pressed_r       <= stable_pressed_s;
      press_pulse_r   <= stable_pressed_s & ~pressed_r;
      release_pulse_r <= ~stable_pressed_s & pressed_r;
    end
  end

  // Auto-repeat timing per channel, rearmed on every fresh press
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      rp_first_r     <= {N_BUTTONS{1'b0}};
      repeat_pulse_r <= {N_BUTTONS{1'b0}};
      for (int i = 0; i < N_BUTTONS; i++) begin
        rp_cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < N_BUTTONS; i++) begin
        if (stable_pressed_s[i] && !pressed_r[i]) begin
          rp_cnt_r[i]       <= CNT_ZERO;
          rp_first_r[i]     <= 1'b1;
          repeat_pulse_r[i] <= 1'b0;
        end else if (stable_pressed_s[i] && RP_EN) begin
          if (rp_first_r[i] && (rp_cnt_r[i] == RP_DELAY_MAX)) begin
            rp_cnt_r[i]       <= CNT_ZERO;
            rp_first_r[i]     <= 1'b0;
            repeat_pulse_r[i] <= 1'b1;
          end else if (!rp_first_r[i] && (rp_cnt_r[i] == RP_PERIOD_MAX)) begin
            rp_cnt_r[i]       <= CNT_ZERO;
            rp_first_r[i]     <= 1'b0;
            repeat_pulse_r[i] <= 1'b1;
          end else begin
            rp_cnt_r[i]       <= rp_cnt_r[i] + CNT_ONE;
            rp_first_r[i]     <= rp_first_r[i];
            repeat_pulse_r[i] <= 1'b0;
          end
        end else begin
          rp_cnt_r[i]       <= CNT_ZERO;
          rp_first_r[i]     <= 1'b0;
          repeat_pulse_r[i] <= 1'b0;
        end
      end
    end
  end

  assign btn.buttons_debounced = debounced_r;
  assign btn.pressed           = pressed_r;
  assign btn.press_pulse       = press_pulse_r;
  assign btn.release_pulse     = release_pulse_r;
  assign btn.repeat_pulse      = repeat_pulse_r;

endmodule
